// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit adder built from one 4-bit slice, sequenced over
// DIGITS = WIDTH/4 cycles, least-significant nibble first.
//
// Optional build macro: SERIAL_ADDER_SUB_EN adds a 'sub' input. When it is
// high at the accept edge, y is inverted and the initial carry forced to 1,
// giving x - y (c_out = 1 means no borrow).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   operands x, y, c_in valid
//   in_ready   controller idle and able to accept (registered)
//   x, y       WIDTH-bit operands
//   c_in       carry into the least-significant digit
//   sub        (SERIAL_ADDER_SUB_EN only) subtract select
//   out_valid  s and c_out valid (registered)
//   out_ready  consumer accepts the result
//   s          sum modulo 2^WIDTH
//   c_out      carry out of the most-significant digit
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   x_sh_q, x_sh_d;
  logic [WIDTH-1:0]   y_sh_q, y_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_out_q, c_out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [4:0]         slice_sum;
  logic [WIDTH-1:0]   y_lat;
  logic               carry_lat;

  // Operand conditioning at latch time (subtract = add inverted y plus one).
  always_comb begin
    y_lat     = y;
    carry_lat = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      y_lat     = ~y;
      carry_lat = 1'b1;
    end
`endif
  end

  // The single 4-bit adder slice.
  assign slice_sum = 5'(x_sh_q[3:0]) + 5'(y_sh_q[3:0]) + 5'(carry_q);

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    res_d   = res_q;
    c_out_d = c_out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_sh_d  = x;
          y_sh_d  = y_lat;
          carry_d = carry_lat;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result fills from the top so the first digit ends up in bits [3:0].
        res_d   = {slice_sum[3:0], res_q[WIDTH-1:4]};
        carry_d = slice_sum[4];
        x_sh_d  = x_sh_q >> 4;
        y_sh_d  = y_sh_q >> 4;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          state_d = DONE;
          c_out_d = slice_sum[4];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the next state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      x_sh_q      <= '0;
      y_sh_q      <= '0;
      res_q       <= '0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      x_sh_q      <= x_sh_d;
      y_sh_q      <= y_sh_d;
      res_q       <= res_d;
      c_out_q     <= c_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = res_q;
  assign c_out     = c_out_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Digit-serial controller that performs one WIDTH-bit addition by sequencing a single 4-bit adder slice (x + y + c_in, carry-out when sum >= 16) over WIDTH/4 clock cycles, least-significant nibble first.
- Holds the carry between digits, shifts operands and assembles the result.
- Presents a valid/ready handshake on both input and output.
- Trades latency for area where a full-width adder is too large.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of 4 and >= 8.
- DIGITS, WIDTH/4: derived localparam, not overridable. Number of slice cycles per operation.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands x, y, c_in valid
- in_ready  output  1  controller can accept an operation
- x  input  WIDTH  first operand
- y  input  WIDTH  second operand
- c_in  input  1  carry into least-significant digit
- out_valid  output  1  s and c_out valid
- out_ready  input  1  consumer accepts the result
- s  output  WIDTH  sum modulo 2^WIDTH
- c_out  output  1  carry out of most-significant digit

Behaviour:
- One clock, clk. reset is synchronous and active-high. Same-edge reset overrides every other action.
- State after reset:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - s = 0, c_out = 0.
  - Digit counter = 0, carry register = 0, operand shift registers = 0.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state with no combinational path from inputs.
- IDLE:
  - When in_valid = 1 (accept edge), latch x and y into shift registers, carry register <= c_in, counter <= 0, next state RUN.
  - Otherwise remain in IDLE.
- RUN: each cycle, the slice computes x_sh[3:0] + y_sh[3:0] + carry.
  - Result register <= {sum[3:0], result[WIDTH-1:4]}.
  - carry <= slice carry-out.
  - x_sh and y_sh shift right by 4.
  - counter <= counter + 1.
  - When counter == DIGITS-1, next state DONE and c_out <= slice carry-out of that digit.
- DONE:
  - s and c_out are held stable.
  - When out_ready = 1, next state IDLE. No other change.
- Latency: out_valid rises exactly DIGITS cycles after the accept edge (4 cycles for WIDTH=16).
- Minimum spacing between accepts is DIGITS+2 cycles. There is no back-to-back restart in DONE.
- Input-side rules:
  - in_valid during RUN or DONE is ignored and not queued. The requester must hold in_valid until it sees in_ready.
  - Changes to x, y or c_in after the accept edge do not affect the result.
- Output-side rules:
  - out_ready while not in DONE is ignored.
  - out_ready held low keeps DONE indefinitely, with s and c_out frozen.
- Arithmetic: s = (x + y + c_in) mod 2^WIDTH, and c_out = ((x + y + c_in) >= 2^WIDTH). This must be bit-identical to a full-width adder.
- Reset during RUN or DONE: the operation is abandoned and the outputs take their reset values on the next edge. No stale out_valid.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled only on the accept edge.
  - If sub = 1, y is inverted at latch time and the initial carry is forced to 1, ignoring c_in. The result is s = x - y mod 2^WIDTH.
  - c_out = 1 means no borrow; c_out = 0 means borrow.
  - If sub = 0, behaviour is unchanged.
- When undefined: there is no sub port and the block is add-only as specified above.

Test Plan:
- WIDTH=16, x=0x1234, y=0x4321, c_in=0, accepted at edge T -> out_valid first high at T+4, s=0x5555, c_out=0.
- x=0xFFFF, y=0x0001, c_in=0 -> carry propagates through all 4 digits, s=0x0000, c_out=1.
- x=0xFFFF, y=0x0000, c_in=1 -> s=0x0000, c_out=1. Also x=0x0000, y=0x0000, c_in=0 -> s=0x0000, c_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - out_valid, s and c_out stay stable and in_ready stays 0.
  - Pulse in_valid with new operands during this time -> ignored.
  - out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert reset for one cycle at the 2nd RUN cycle.
  - Next cycle: in_ready=1, out_valid=0, s=0, c_out=0.
  - A following operation 0x00FF+0x0001 -> s=0x0100, c_out=0.
- With SERIAL_ADDER_SUB_EN, sub=1:
  - x=0x0005, y=0x0007 -> s=0xFFFE, c_out=0.
  - x=0x0007, y=0x0005 -> s=0x0002, c_out=1.
